rle_stream_sched: RTL and testbench

Output scheduler for the DWT + hard-threshold + RLE compression path. It accepts the two free-running RLE record streams (approximation channel A, detail channel D), buffers each in its own FIFO, and arbitrates between them round-robin. The winning record is serialised onto a single 8-bit ready/valid byte stream: value byte first, then count byte, with a channel tag. Overflow of either FIFO is flagged, never stalls upstream.

---
 rtl/rle_stream_sched.sv | 207 ++++++++++++++++++++
 tb/tb_rle_stream_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_stream_sched.sv
// RLE output scheduler: two record FIFOs (A and D) arbitrated round-robin and
// serialised as value byte then count byte on one ready/valid byte stream.

// Single-clock record FIFO with wrap-bit pointers and a combinational head.
module rle_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [15:0]   din,
    input  logic          pop,
    output logic [15:0]   head,
    output logic [AW:0]   level
);

    logic [15:0] mem [DEPTH];
    logic [AW:0] wr;
    logic [AW:0] rd;

    // Pointer update; a push into a full FIFO is only issued alongside a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push) wr <= wr + (AW+1)'(1);
            if (pop)  rd <= rd + (AW+1)'(1);
        end
    end

    // Storage write; when full the written slot is the one being popped.
    always_ff @(posedge clk) begin
        if (push) mem[wr[AW-1:0]] <= din;
    end

    assign head  = mem[rd[AW-1:0]];
    assign level = wr - rd;

endmodule

module rle_stream_sched #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [7:0]    a_value,
    input  logic [7:0]    a_count,
    input  logic          d_valid,
    input  logic [7:0]    d_value,
    input  logic [7:0]    d_count,
    input  logic          clr_ovf,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [7:0]    m_data,
    output logic          m_chan,
    output logic          m_last,
    output logic          a_ovf,
    output logic          d_ovf,
    output logic [AW:0]   a_level,
    output logic [AW:0]   d_level
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_VAL = 2'd1,
        SEND_CNT = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic        grant, grant_nx;
    logic        prio, prio_nx;
    logic [15:0] hold, hold_nx;
    logic        m_valid_nx, m_chan_nx, m_last_nx;
    logic [7:0]  m_data_nx;

    logic        a_push, d_push, a_pop, d_pop;
    logic        a_ne, d_ne;
    logic [15:0] a_head, d_head;

    assign a_ne   = (a_level != '0);
    assign d_ne   = (d_level != '0);
    assign a_push = a_valid && ((a_level < FULL) || a_pop);
    assign d_push = d_valid && ((d_level < FULL) || d_pop);

    rle_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (a_push),
        .din   ({a_value, a_count}),
        .pop   (a_pop),
        .head  (a_head),
        .level (a_level)
    );

    rle_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_d (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (d_push),
        .din   ({d_value, d_count}),
        .pop   (d_pop),
        .head  (d_head),
        .level (d_level)
    );

    // State, grant, holding register, priority pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= 1'b0;
            prio    <= 1'b0;
            hold    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            prio    <= prio_nx;
            hold    <= hold_nx;
            m_valid <= m_valid_nx;
            m_data  <= m_data_nx;
            m_chan  <= m_chan_nx;
            m_last  <= m_last_nx;
        end
    end

    // Next state and arbitration; the pointer flip after a record applies to the immediate re-grant.
    always_comb begin
        logic opp;
        logic eff_prio;
        logic pick;
        state_nx = state;
        grant_nx = grant;
        prio_nx  = prio;
        hold_nx  = hold;
        a_pop    = 1'b0;
        d_pop    = 1'b0;
        opp      = 1'b0;
        eff_prio = prio;
        pick     = 1'b0;
        case (state)
            IDLE:     opp = 1'b1;
            SEND_VAL: if (m_ready) state_nx = SEND_CNT;
            SEND_CNT: begin
                if (m_ready) begin
                    opp      = 1'b1;
                    prio_nx  = ~grant;
                    eff_prio = ~grant;
                    state_nx = IDLE;
                end
            end
            default:  state_nx = IDLE;
        endcase
        if (opp && (a_ne || d_ne)) begin
            pick     = eff_prio ? d_ne : ~a_ne;
            a_pop    = ~pick;
            d_pop    = pick;
            grant_nx = pick;
            hold_nx  = pick ? d_head : a_head;
            state_nx = SEND_VAL;
        end
    end

    // Output values for the coming state, taken from the next holding register.
    always_comb begin
        m_valid_nx = 1'b0;
        m_data_nx  = m_data;
        m_chan_nx  = m_chan;
        m_last_nx  = m_last;
        case (state_nx)
            SEND_VAL: begin
                m_valid_nx = 1'b1;
                m_data_nx  = hold_nx[15:8];
                m_chan_nx  = grant_nx;
                m_last_nx  = 1'b0;
            end
            SEND_CNT: begin
                m_valid_nx = 1'b1;
                m_data_nx  = hold_nx[7:0];
                m_chan_nx  = grant_nx;
                m_last_nx  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sticky overflow flags; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ovf <= 1'b0;
            d_ovf <= 1'b0;
        end else begin
            if (a_valid && !a_push) a_ovf <= 1'b1;
            else if (clr_ovf)       a_ovf <= 1'b0;
            if (d_valid && !d_push) d_ovf <= 1'b1;
            else if (clr_ovf)       d_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rle_stream_sched.sv
// Bench for rle_stream_sched: cycle vector table plus directed corner sequences,
// with per-channel scoreboards checking every accepted output byte.
module tb_rle_stream_sched;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, d_valid, clr_ovf, m_ready;
    logic [7:0]    a_value, a_count, d_value, d_count;
    logic          m_valid, m_chan, m_last, a_ovf, d_ovf;
    logic [7:0]    m_data;
    logic [AW:0]   a_level, d_level;

    int total   = 0;
    int bad     = 0;
    int d_bytes = 0;

    logic [8:0] sb_a[$];
    logic [8:0] sb_d[$];

    typedef struct packed {
        logic       av;
        logic [7:0] avl;
        logic [7:0] acn;
        logic       dv;
        logic [7:0] dvl;
        logic [7:0] dcn;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       ec;
        logic       el;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    rle_stream_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_value (a_value),
        .a_count (a_count),
        .d_valid (d_valid),
        .d_value (d_value),
        .d_count (d_count),
        .clr_ovf (clr_ovf),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_chan  (m_chan),
        .m_last  (m_last),
        .a_ovf   (a_ovf),
        .d_ovf   (d_ovf),
        .a_level (a_level),
        .d_level (d_level)
    );

    function automatic vec_t mk(input logic av, input logic [7:0] avl, input logic [7:0] acn,
                                input logic dv, input logic [7:0] dvl, input logic [7:0] dcn,
                                input logic rdy, input logic ev, input logic [7:0] ed,
                                input logic ec, input logic el);
        vec_t v;
        v.av = av; v.avl = avl; v.acn = acn;
        v.dv = dv; v.dvl = dvl; v.dcn = dcn;
        v.rdy = rdy; v.ev = ev; v.ed = ed; v.ec = ec; v.el = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [15:0] got);
        total++;
        bad++;
        $display("FAIL %s: got=0x%0h want=nothing pending", name, got);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic ch, input logic [7:0] v, input logic [7:0] c);
        if (ch) begin
            sb_d.push_back({1'b0, v});
            sb_d.push_back({1'b1, c});
        end else begin
            sb_a.push_back({1'b0, v});
            sb_a.push_back({1'b1, c});
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_value = 8'h00; a_count = 8'h00;
        d_valid = 1'b0; d_value = 8'h00; d_count = 8'h00;
        clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        m_ready = 1'b0;
        rst_n   = 1'b0;
        sb_a.delete();
        sb_d.delete();
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain(input int maxc);
        m_ready = 1'b1;
        for (int k = 0; k < maxc; k++) begin
            step();
            if (sb_a.size() == 0 && sb_d.size() == 0 && !m_valid) break;
        end
        chk("drain_left", 16'(sb_a.size() + sb_d.size()), 16'd0);
        chk("drain_idle", 16'(m_valid), 16'd0);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            a_valid = tbl[i].av; a_value = tbl[i].avl; a_count = tbl[i].acn;
            d_valid = tbl[i].dv; d_value = tbl[i].dvl; d_count = tbl[i].dcn;
            m_ready = tbl[i].rdy;
            if (tbl[i].av) push_exp(1'b0, tbl[i].avl, tbl[i].acn);
            if (tbl[i].dv) push_exp(1'b1, tbl[i].dvl, tbl[i].dcn);
            step();
            chk($sformatf("vec%0d_valid", i), 16'(m_valid), 16'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_data", i), 16'(m_data), 16'(tbl[i].ed));
                chk($sformatf("vec%0d_chan", i), 16'(m_chan), 16'(tbl[i].ec));
                chk($sformatf("vec%0d_last", i), 16'(m_last), 16'(tbl[i].el));
            end
        end
        idle_inputs();
    endtask

    // Every byte accepted downstream must match the head of its channel's scoreboard.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (m_chan) begin
                d_bytes++;
                if (sb_d.size() == 0) fail_unexpected("sb_d", 16'({m_last, m_data}));
                else chk("sb_d", 16'({m_last, m_data}), 16'(sb_d.pop_front()));
            end else begin
                if (sb_a.size() == 0) fail_unexpected("sb_a", 16'({m_last, m_data}));
                else chk("sb_a", 16'({m_last, m_data}), 16'(sb_a.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single record, then A/D round-robin with simultaneous pushes.
        tbl[0]  = mk(1'b1, 8'h05, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 8'h11, 8'h21, 1'b1, 8'h81, 8'h91, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 8'h12, 8'h22, 1'b1, 8'h82, 8'h92, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 8'h13, 8'h23, 1'b1, 8'h83, 8'h93, 1'b1, 1'b1, 8'h21, 1'b0, 1'b1);
        tbl[7]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h91, 1'b1, 1'b1);
        tbl[9]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h82, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h92, 1'b1, 1'b1);
        tbl[13] = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h23, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h83, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h93, 1'b1, 1'b1);
        tbl[17] = mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset values while reset is held.
        idle_inputs();
        m_ready = 1'b0;
        rst_n   = 1'b0;
        step();
        step();
        chk("rst_valid", 16'(m_valid), 16'd0);
        chk("rst_data",  16'(m_data),  16'd0);
        chk("rst_chan",  16'(m_chan),  16'd0);
        chk("rst_last",  16'(m_last),  16'd0);
        chk("rst_ovf",   16'({a_ovf, d_ovf}), 16'd0);
        chk("rst_level", 16'({a_level, d_level}), 16'd0);

        do_reset();
        run_vecs(0, 3);
        do_reset();
        run_vecs(4, 17);

        // Backpressure on the value byte of 0xF6.
        m_ready = 1'b0;
        a_valid = 1'b1; a_value = 8'hF6; a_count = 8'h07;
        push_exp(1'b0, 8'hF6, 8'h07);
        step();
        a_valid = 1'b0;
        step();
        chk("bp_first", 16'({m_valid, m_last, m_data}), 16'({1'b1, 1'b0, 8'hF6}));
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_hold%0d", c), 16'({m_valid, m_chan, m_last, m_data}),
                16'({1'b1, 1'b0, 1'b0, 8'hF6}));
        end
        m_ready = 1'b1;
        step();
        chk("bp_count", 16'({m_valid, m_last, m_data}), 16'({1'b1, 1'b1, 8'h07}));
        step();
        chk("bp_idle", 16'(m_valid), 16'd0);

        // Overflow on D while the scheduler is stalled on an A record.
        m_ready = 1'b0;
        a_valid = 1'b1; a_value = 8'h40; a_count = 8'h01;
        push_exp(1'b0, 8'h40, 8'h01);
        step();
        a_valid = 1'b0;
        step();
        for (int i = 0; i < 9; i++) begin
            d_valid = 1'b1;
            d_value = 8'(208 + i);
            d_count = 8'(i + 1);
            if (i < 8) push_exp(1'b1, d_value, d_count);
            step();
        end
        d_valid = 1'b0;
        chk("ovf_d_level", 16'(d_level), 16'd8);
        chk("ovf_d_flag",  16'(d_ovf),   16'd1);
        chk("ovf_a_flag",  16'(a_ovf),   16'd0);
        d_bytes = 0;
        drain(60);
        chk("ovf_d_bytes", 16'(d_bytes), 16'd16);
        chk("ovf_sticky",  16'(d_ovf),   16'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 16'(d_ovf), 16'd0);

        // Full A FIFO accepting a push in the cycle it is popped.
        m_ready = 1'b0;
        a_valid = 1'b1; a_value = 8'h60; a_count = 8'h10;
        push_exp(1'b0, 8'h60, 8'h10);
        step();
        for (int i = 1; i <= 8; i++) begin
            a_value = 8'(96 + i);
            a_count = 8'(16 + i);
            push_exp(1'b0, a_value, a_count);
            step();
        end
        a_valid = 1'b0;
        chk("full_level", 16'(a_level), 16'd8);
        m_ready = 1'b1;
        step();
        a_valid = 1'b1; a_value = 8'h6F; a_count = 8'h1F;
        push_exp(1'b0, 8'h6F, 8'h1F);
        step();
        a_valid = 1'b0;
        chk("pp_level", 16'(a_level), 16'd8);
        chk("pp_ovf",   16'(a_ovf),   16'd0);
        drain(80);

        // Asynchronous reset between value byte and count byte.
        m_ready = 1'b1;
        a_valid = 1'b1; a_value = 8'h5A; a_count = 8'h3C;
        push_exp(1'b0, 8'h5A, 8'h3C);
        step();
        a_valid = 1'b0;
        d_valid = 1'b1; d_value = 8'h99; d_count = 8'h11;
        step();
        d_valid = 1'b0;
        chk("ar_val", 16'({m_valid, m_last, m_data}), 16'({1'b1, 1'b0, 8'h5A}));
        step();
        chk("ar_cnt", 16'({m_valid, m_last, m_data}), 16'({1'b1, 1'b1, 8'h3C}));
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", 16'(m_valid), 16'd0);
        chk("ar_data",  16'(m_data),  16'd0);
        chk("ar_flags", 16'({m_chan, m_last}), 16'd0);
        chk("ar_level", 16'({a_level, d_level}), 16'd0);
        sb_a.delete();
        sb_d.delete();
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b1; a_value = 8'h77; a_count = 8'h01;
        push_exp(1'b0, 8'h77, 8'h01);
        step();
        a_valid = 1'b0;
        chk("ar_post_idle", 16'(m_valid), 16'd0);
        step();
        chk("ar_post_first", 16'({m_valid, m_chan, m_last, m_data}),
            16'({1'b1, 1'b0, 1'b0, 8'h77}));
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
